cosine_frame_loader: RTL and testbench
======================================

# cosine_frame_loader

Upstream feeder for the cosine similarity engine. It accepts a stream of (a, b) IEEE-754 single-precision element pairs over a valid/ready handshake and assembles them into W-element vector registers. Once a frame is complete it pulses `start` to the engine and holds the vectors stable while the engine runs. It then captures the engine's `similarity` result and presents it on a valid/ready result port, and detects framing errors on the input stream.

## Interface
Parameters:
- `W`, 5: elements per vector; must match engine `W`; 2..8.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: loader accepts a beat this cycle.
- `in_a`, input, 32: element of vector A, float32 bit pattern.
- `in_b`, input, 32: element of vector B, float32 bit pattern.
- `in_last`, input, 1: marks the final beat of a frame; legal only on beat index W-1.
- `vec_a`, output, 32 x W: assembled vector A, to the engine; signed [31:0] array [W-1:0].
- `vec_b`, output, 32 x W: assembled vector B, to the engine.
- `start`, output, 1: one-cycle pulse to the engine.
- `sim_valid`, input, 1: engine result valid (one-cycle pulse).
- `similarity`, input, 32: engine result.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, 32: captured similarity.
- `busy`, output, 1: high in KICK or BUSY state.
- `err_cnt`, output, 8: count of dropped frames, saturating at 255.

## Operation
- States:
  - FILL: collect beats.
  - FLUSH: discard beats until the end of a bad frame.
  - KICK: pulse `start`.
  - BUSY: wait for the engine.
  - HOLD: offer the result.
- Beat transfer occurs when `in_valid && in_ready`.
- `in_ready` = 1 in FILL and FLUSH, 0 otherwise. It is combinational from state only and never depends on `in_valid`.
- FILL, on a transfer at write index `wr_idx`:
  - Write `vec_a[wr_idx]` = `in_a` and `vec_b[wr_idx]` = `in_b`.
  - `wr_idx` < W-1 and `in_last` = 0: `wr_idx`++, stay in FILL.
  - `wr_idx` < W-1 and `in_last` = 1 (early last): drop the frame. `wr_idx` <= 0, `err_cnt`++, stay in FILL. Stale vector contents are permitted.
  - `wr_idx` == W-1 and `in_last` = 1: `wr_idx` <= 0, go to KICK.
  - `wr_idx` == W-1 and `in_last` = 0 (missing last): `err_cnt`++, `wr_idx` <= 0, go to FLUSH.
- FLUSH: discard every beat. Go to FILL on the cycle after the first transferred beat with `in_last` = 1.
- KICK: `start` = 1 for exactly this one cycle, then go to BUSY.
- BUSY: `vec_a` and `vec_b` must not change. When `sim_valid` = 1, capture `res_data` <= `similarity` and go to HOLD.
- HOLD: `res_valid` = 1. `res_data` is stable until `res_ready` = 1. On handshake, go to FILL.
- `sim_valid` outside BUSY is ignored and does not change `res_data`.
- `err_cnt` saturates at 255: it does not increment past 255 and does not wrap.
- No arithmetic is performed on data. Float bit patterns pass through unmodified.

## Timing
- Reset values:
  - State FILL, `wr_idx` 0.
  - `start` 0, `res_valid` 0, `res_data` 0, `busy` 0, `err_cnt` 0.
  - All `vec_a`/`vec_b` entries 0.
  - `in_ready` 1; no transfer is registered while `rst_n` = 0.
- Last beat accepted at cycle t: `start` = 1 at t+1, `busy` = 1 from t+1.
- `sim_valid` at cycle s: `res_valid` = 1 at s+1.
- Result handshake at cycle h: `res_valid` = 0 and `in_ready` = 1 at h+1.
- Minimum frame-to-frame period: W + 3 + engine latency.
- `in_valid` gaps are allowed at any beat. No beat is lost or duplicated.
- `start` is never asserted twice for one frame. It is not asserted again until the prior result has been handshaken.
- Reset mid-operation (any state) returns all state and outputs to reset values within the same cycle; the engine shares `rst_n`. A partially loaded frame is discarded.

## Test plan
- **Nominal frame:** W=5 beats, a=3F800000 (1.0) and b=40000000 (2.0), `in_last` on beat 4.
  - `start` is a single pulse one cycle after beat 4.
  - `vec_a[0..4]` all equal 3F800000.
  - An engine stub returns 3F800000 after 20 cycles; `res_data` = 3F800000 and `res_valid` rises one cycle after `sim_valid`.
- **Result backpressure:** hold `res_ready` = 0 for 10 cycles in HOLD.
  - `res_valid` stays 1, `res_data` is stable, `in_ready` = 0.
  - On release, `in_ready` = 1 the next cycle.
- **Early last:** `in_last` on beat 2.
  - `err_cnt` = 1, no `start` pulse.
  - A following good 5-beat frame produces exactly one `start`.
- **Missing last:** 7 beats, `in_last` on beat 6.
  - `err_cnt` = 1, no `start` pulse, loader back in FILL after beat 6.
  - The next good frame works normally.
- **Gapped input:** `in_valid` toggled randomly over a frame of values 0x01..0x05.
  - `vec_a` = {1,2,3,4,5} in index order.
  - `vec` registers unchanged during BUSY even if `in_valid` = 1.
- **Reset mid-BUSY:** assert `rst_n` = 0 while the stub is counting.
  - All outputs return to reset values immediately.
  - A stray `sim_valid` after reset deasserts leaves `res_valid` = 0.

Source files
------------

// File: rtl/cosine_frame_loader.sv
// Stream-to-vector loader for the cosine similarity engine: assembles W (a, b) float32 pairs,
// kicks the engine, captures its result and counts dropped (mis-framed) input frames.
module cosine_frame_loader #(
  parameter int unsigned W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic               in_last,
  output logic signed [31:0] vec_a [W],
  output logic signed [31:0] vec_b [W],
  output logic               start,
  input  logic               sim_valid,
  input  logic [31:0]        similarity,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam int unsigned IdxW = $clog2(W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(W - 1);

  typedef enum logic [2:0] {StFill, StFlush, StKick, StBusy, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [31:0]       res_data_q, res_data_d;
  logic signed [31:0] vec_a_q [W];
  logic signed [31:0] vec_b_q [W];
  logic              vec_we;
  logic              err_inc;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    res_data_d = res_data_q;
    vec_we     = 1'b0;
    err_inc    = 1'b0;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_we = 1'b1;
          if (wr_idx_q == LastIdx) begin
            wr_idx_d = '0;
            if (in_last) begin
              state_d = StKick;
            end else begin
              // Missing last: drop the rest of this frame in FLUSH.
              err_inc = 1'b1;
              state_d = StFlush;
            end
          end else if (in_last) begin
            wr_idx_d = '0;
            err_inc  = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StFlush: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = StFill;
        end
      end
      StKick: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = StBusy;
      end
      StBusy: begin
        busy = 1'b1;
        if (sim_valid) begin
          res_data_d = similarity;
          state_d    = StHold;
        end
      end
      StHold: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      wr_idx_q   <= '0;
      err_cnt_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      err_cnt_q  <= err_cnt_d;
      res_data_q <= res_data_d;
    end
  end

  // Vectors are written only in FILL, so they stay frozen while the engine runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        vec_a_q[i] <= '0;
        vec_b_q[i] <= '0;
      end
    end else if (vec_we) begin
      vec_a_q[wr_idx_q] <= in_a;
      vec_b_q[wr_idx_q] <= in_b;
    end
  end

  assign vec_a    = vec_a_q;
  assign vec_b    = vec_b_q;
  assign res_data = res_data_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_cosine_frame_loader.sv
// Scoreboard bench for cosine_frame_loader with a fixed-latency engine stub that returns vec_a[0].
module tb_cosine_frame_loader;

  localparam int unsigned W = 5;
  localparam int unsigned EngLat = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_a = '0;
  logic [31:0]        in_b = '0;
  logic               in_last = 1'b0;
  logic signed [31:0] vec_a [W];
  logic signed [31:0] vec_b [W];
  logic               start;
  logic               sim_valid;
  logic [31:0]        similarity;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [31:0]        res_data;
  logic               busy;
  logic [7:0]         err_cnt;

  logic        stub_sv;
  logic [31:0] stub_sim;
  logic        stray_sv = 1'b0;
  int unsigned stub_cnt;
  logic        stub_active;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int exp_err = 0;
  logic        prev_start = 1'b0;
  logic        sim_armed = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_vec_a [W];
  logic [31:0] exp_vec_b [W];

  cosine_frame_loader #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .start      (start),
    .sim_valid  (sim_valid),
    .similarity (similarity),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  assign sim_valid  = stub_sv | stray_sv;
  assign similarity = stray_sv ? 32'hDEAD_BEEF : stub_sim;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_sv     <= 1'b0;
      stub_sim    <= '0;
      stub_cnt    <= 0;
      stub_active <= 1'b0;
    end else begin
      stub_sv <= 1'b0;
      if (start) begin
        stub_active <= 1'b1;
        stub_cnt    <= EngLat;
      end else if (stub_active) begin
        if (stub_cnt == 1) begin
          stub_sv     <= 1'b1;
          stub_sim    <= vec_a[0];
          stub_active <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start-pulse, vector-content and sim->res latency monitor.
  always @(negedge clk) begin
    if (rst_n && start) begin
      start_cnt++;
      check("start_single", 32'(prev_start), 32'd0);
      for (int i = 0; i < W; i++) begin
        check("vec_a_at_start", vec_a[i], exp_vec_a[i]);
        check("vec_b_at_start", vec_b[i], exp_vec_b[i]);
      end
    end
    if (sim_armed) check("res_valid_after_sim", 32'(res_valid), 32'd1);
    sim_armed  = rst_n && sim_valid && busy;
    prev_start = rst_n && start;
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [31:0] a_base,
                            input logic [31:0] b_base, input logic [31:0] inc, input bit gapped);
    logic [31:0] a;
    logic [31:0] b;
    bit good;
    good = (n == W) && (last_at == W - 1);
    for (int i = 0; i < n; i++) begin
      a = a_base + 32'(i) * inc;
      b = b_base + 32'(i) * inc;
      if (good) begin
        exp_vec_a[i] = a;
        exp_vec_b[i] = b;
      end
      if (gapped) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_beat(a, b, i == last_at);
    end
    if (good) exp_q.push_back(a_base);
    else if (exp_err < 255) exp_err++;
  endtask

  task automatic take_result(input int hold_cycles);
    int guard = 0;
    logic [31:0] exp;
    do begin
      @(negedge clk);
      guard++;
      if (!res_valid) begin
        // Junk beats while the engine runs must not disturb the vectors.
        in_valid = 1'b1;
        in_a     = $urandom;
        in_b     = $urandom;
        in_last  = 1'($urandom);
      end
    end while (!res_valid && guard < 100);
    in_valid = 1'b0;
    check("res_valid_timeout", 32'(res_valid), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
    check("res_data", res_data, exp);
    for (int i = 0; i < W; i++) check("vec_a_busy_stable", vec_a[i], exp_vec_a[i]);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", res_data, exp);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("post_hs_res_valid", 32'(res_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < W; i++) begin
      check({tag, "_vec_a"}, vec_a[i], 32'd0);
      check({tag, "_vec_b"}, vec_b[i], 32'd0);
    end
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Nominal frame of constants 1.0 / 2.0.
    s0 = start_cnt;
    send_frame(W, W - 1, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b0);
    @(negedge clk);
    check("start_after_last", 32'(start), 32'd1);
    check("busy_after_last", 32'(busy), 32'd1);
    take_result(0);
    check("nominal_starts", 32'(start_cnt - s0), 32'd1);

    // Result backpressure.
    send_frame(W, W - 1, 32'h4040_0000, 32'h4080_0000, 32'd1, 1'b0);
    take_result(10);

    // Early last, then a good frame.
    s0 = start_cnt;
    send_frame(3, 2, 32'h0000_0100, 32'h0000_0200, 32'd1, 1'b0);
    @(negedge clk);
    check("early_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("early_no_start", 32'(start_cnt - s0), 32'd0);
    send_frame(W, W - 1, 32'h1111_0000, 32'h2222_0000, 32'd3, 1'b0);
    take_result(0);
    check("early_next_starts", 32'(start_cnt - s0), 32'd1);

    // Missing last: 7 beats with last on beat 6.
    s0 = start_cnt;
    send_frame(7, 6, 32'h0000_0A00, 32'h0000_0B00, 32'd1, 1'b0);
    @(negedge clk);
    check("missing_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("missing_no_start", 32'(start_cnt - s0), 32'd0);
    check("missing_in_ready", 32'(in_ready), 32'd1);
    check("missing_busy", 32'(busy), 32'd0);
    send_frame(W, W - 1, 32'h7777_0001, 32'h8888_0002, 32'd5, 1'b0);
    take_result(2);
    check("missing_next_starts", 32'(start_cnt - s0), 32'd1);

    // Gapped input, values 1..5.
    send_frame(W, W - 1, 32'd1, 32'h0000_0011, 32'd1, 1'b1);
    take_result(0);
    for (int i = 0; i < W; i++) check("gapped_vec_a", vec_a[i], 32'(i + 1));

    // Error counter saturation via single-beat early-last frames.
    for (int i = 0; i < 260; i++) send_frame(1, 0, 32'(i), 32'(i), 32'd0, 1'b0);
    @(negedge clk);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    // Reset while the engine stub is counting.
    send_frame(W, W - 1, 32'hCAFE_0000, 32'hF00D_0000, 32'd1, 1'b0);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midbusy");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_sv = 1'b1;
    @(negedge clk);
    stray_sv = 1'b0;
    @(negedge clk);
    check("stray_res_valid", 32'(res_valid), 32'd0);
    check("stray_res_data", res_data, 32'd0);
    repeat (EngLat + 5) @(negedge clk);
    check("no_late_result", 32'(res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
